// File: rtl/meter_ctrl.sv
// Parking-meter time register: merges coin pulses and preset loads into a saturating
// seconds count, decrements once per second, and derives state/blanking for the display.
module meter_ctrl #(
    parameter int unsigned CLK_PER_SEC = 100000000,
    parameter int unsigned MAX_COUNT   = 9999,
    parameter int unsigned LOW_THRESH  = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  coin,
    input  logic [1:0]  preset,
    output logic [15:0] count,
    output logic [1:0]  state,
    output logic        blank,
    output logic        expired
);

    localparam int unsigned SEC_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_LOW   = 2'b01,
        ST_OK    = 2'b10
    } meter_state_e;

    logic [SEC_W-1:0] sec_q, sec_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] count_q, count_d;
    meter_state_e     state_q, state_d;
    logic             blank_q, blank_d;
    logic             expired_q, expired_d;

    logic             tick;
    logic             dec;
    logic [SUM_W-1:0] add;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] diff;

    // Next-state: coin/tick arithmetic, then preset override, then classification from next count.
    always_comb begin
        add = '0;
        if (coin[0]) add = add + SUM_W'(10);
        if (coin[1]) add = add + SUM_W'(180);
        if (coin[2]) add = add + SUM_W'(200);
        if (coin[3]) add = add + SUM_W'(550);

        tick = (sec_q == SEC_W'(CLK_PER_SEC - 1));
        sum  = SUM_W'(count_q) + add;
        dec  = tick && (sum != '0);
        diff = sum - SUM_W'(dec);

        sec_d     = tick ? '0 : sec_q + SEC_W'(1);
        parity_d  = parity_q ^ tick;
        count_d   = (diff > SUM_W'(MAX_COUNT)) ? CNT_W'(MAX_COUNT) : diff[CNT_W-1:0];
        expired_d = tick && (add == '0) && (count_q == CNT_W'(1));

        if (preset[0] || preset[1]) begin
            count_d   = preset[0] ? CNT_W'(10) : CNT_W'(205);
            sec_d     = '0;
            parity_d  = 1'b0;
            expired_d = 1'b0;
        end

        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (count_d < CNT_W'(LOW_THRESH)) begin
            state_d = ST_LOW;
        end else begin
            state_d = ST_OK;
        end

        // LOW blinks at 1 s from parity; EMPTY blinks at 0.5 s from the divider phase.
        case (state_d)
            ST_OK:   blank_d = 1'b0;
            ST_LOW:  blank_d = parity_d;
            default: blank_d = (sec_d >= SEC_W'(CLK_PER_SEC / 2));
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q     <= '0;
            parity_q  <= 1'b0;
            count_q   <= '0;
            state_q   <= ST_EMPTY;
            blank_q   <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            sec_q     <= sec_d;
            parity_q  <= parity_d;
            count_q   <= count_d;
            state_q   <= state_d;
            blank_q   <= blank_d;
            expired_q <= expired_d;
        end
    end

    assign count   = count_q;
    assign state   = state_q;
    assign blank   = blank_q;
    assign expired = expired_q;

endmodule
